// File: rtl/fifo_axi_writer.sv
// fifo_axi_writer: drains a FIFO into AXI4 INCR write bursts under ap_ctrl_hs control.
// One burst is outstanding at a time (AW -> W -> B); a 2-entry holding buffer
// absorbs the 1-cycle FIFO read latency so W beats can run back to back.
// Optional feature: define FIFO_AXI_WRITER_BRESP_CHECK_EN to make err a sticky
// flag for non-OKAY write responses; otherwise err is tied low.
module fifo_axi_writer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [31:0]          base_addr,
  input  logic [31:0]          size,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  input  logic                 fifo_empty,
  output logic [31:0]          m_axi_awaddr,
  output logic [7:0]           m_axi_awlen,
  output logic [2:0]           m_axi_awsize,
  output logic [1:0]           m_axi_awburst,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [WIDTH-1:0]     m_axi_wdata,
  output logic [WIDTH/8-1:0]   m_axi_wstrb,
  output logic                 m_axi_wlast,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  output logic                 err
);

  localparam int unsigned BYTES      = WIDTH / 8;
  localparam logic [2:0]  AWSIZE     = 3'($clog2(BYTES));
  localparam logic [1:0]  BURST_INCR = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_e;

  // Beats in the next burst: min(remaining, MAX_BURST).
  function automatic logic [8:0] burst_beats(input logic [31:0] rem);
    if (rem >= 32'(MAX_BURST)) return 9'(MAX_BURST);
    return rem[8:0];
  endfunction

  state_e            state_q;
  logic [31:0]       remaining_q;
  logic [31:0]       awaddr_q;
  logic [7:0]        awlen_q;
  logic [2:0]        awsize_q;
  logic [1:0]        awburst_q;
  logic              awvalid_q;
  logic              bready_q;
  logic              done_q;
  logic              idle_q;
  logic [8:0]        req_cnt_q;
  logic [8:0]        beat_cnt_q;

  logic [WIDTH-1:0]  buf_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              rd_pending_q;

  logic [8:0]        burst_len_d;
  logic [31:0]       rem_after_d;
  logic [31:0]       addr_after_d;
  logic [1:0]        occ_after_d;
  logic              wvalid_d;
  logic              pop_d;
  logic              last_beat_d;

  assign burst_len_d  = {1'b0, awlen_q} + 9'd1;
  assign rem_after_d  = remaining_q - 32'(burst_len_d);
  assign addr_after_d = awaddr_q + 32'(burst_len_d) * BYTES;

  assign wvalid_d    = (count_q != 2'd0);
  assign pop_d       = wvalid_d && m_axi_wready;
  assign last_beat_d = (beat_cnt_q == burst_len_d - 9'd1);

  // A read issued now lands in the buffer one cycle later, so it is allowed
  // only if the occupancy after this cycle's push/pop leaves a free slot.
  assign occ_after_d = count_q + {1'b0, rd_pending_q} - {1'b0, pop_d};

  assign fifo_rd_en = (state_q == S_W) && !fifo_empty &&
                      (req_cnt_q < burst_len_d) && (occ_after_d <= 2'd1);

  assign ap_ready = ap_rst_n && (state_q == S_IDLE) && ap_start;
  assign ap_done  = done_q;
  assign ap_idle  = idle_q;

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = awsize_q;
  assign m_axi_awburst = awburst_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_d;
  assign m_axi_wdata   = buf_q[rd_ptr_q];
  assign m_axi_wstrb   = {BYTES{wvalid_d}};
  assign m_axi_wlast   = wvalid_d && last_beat_d;
  assign m_axi_bready  = bready_q;

  // Control FSM: sequences AW, W and B of one burst at a time.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awsize_q    <= '0;
      awburst_q   <= '0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      idle_q      <= 1'b1;
      req_cnt_q   <= '0;
      beat_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            remaining_q <= size;
            awaddr_q    <= base_addr;
            idle_q      <= 1'b0;
            if (size != 32'd0) begin
              awlen_q   <= 8'(burst_beats(size) - 9'd1);
              awsize_q  <= AWSIZE;
              awburst_q <= BURST_INCR;
              awvalid_q <= 1'b1;
              state_q   <= S_AW;
            end else begin
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            awvalid_q  <= 1'b0;
            req_cnt_q  <= '0;
            beat_cnt_q <= '0;
            state_q    <= S_W;
          end
        end
        S_W: begin
          if (fifo_rd_en) req_cnt_q <= req_cnt_q + 9'd1;
          if (pop_d) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
            if (last_beat_d) begin
              bready_q <= 1'b1;
              state_q  <= S_B;
            end
          end
        end
        S_B: begin
          if (m_axi_bvalid && bready_q) begin
            bready_q    <= 1'b0;
            remaining_q <= rem_after_d;
            awaddr_q    <= addr_after_d;
            if (rem_after_d != 32'd0) begin
              awlen_q   <= 8'(burst_beats(rem_after_d) - 9'd1);
              awvalid_q <= 1'b1;
              state_q   <= S_AW;
            end else begin
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Holding buffer: captures FIFO data one cycle after each read, drains on W handshakes.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= fifo_rd_en;
      if (rd_pending_q) begin
        buf_q[wr_ptr_q] <= fifo_rd_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_d) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, rd_pending_q} - {1'b0, pop_d};
    end
  end

`ifdef FIFO_AXI_WRITER_BRESP_CHECK_EN
  logic err_q;

  // Sticky error on any non-OKAY response; cleared by reset or an accepted start.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_q <= 1'b0;
    end else if ((state_q == S_IDLE) && ap_start) begin
      err_q <= 1'b0;
    end else if ((state_q == S_B) && m_axi_bvalid && bready_q && (m_axi_bresp != 2'b00)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic bresp_unused;
  assign bresp_unused = ^m_axi_bresp;
  assign err          = 1'b0;
`endif

endmodule

// File: doc/fifo_axi_writer.md
FIFO_AXI_WRITER -- requirements
Module: fifo_axi_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, FIFO word and AXI data width in bits (32, 64 or 128).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum beats per AXI burst (power of 2, 1..256).
REQ-003 SHALL have ap_clk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have base_addr  in  32  byte start address, aligned to MAX_BURST*WIDTH/8; size  in  32  total beats to write.
REQ-006 SHALL have ap_start in 1, and ap_done, ap_idle, ap_ready out 1 each, with ap_ctrl_hs semantics.
REQ-007 SHALL have fifo_rd_en  out  1, fifo_rd_data  in  WIDTH, and fifo_empty  in  1, all on the FIFO read port.
REQ-008 SHALL have m_axi_awaddr out 32, m_axi_awlen out 8, m_axi_awsize out 3, m_axi_awburst out 2, m_axi_awvalid out 1 and m_axi_awready in 1.
REQ-009 SHALL have m_axi_wdata out WIDTH, m_axi_wstrb out WIDTH/8, m_axi_wlast out 1, m_axi_wvalid out 1 and m_axi_wready in 1.
REQ-010 SHALL have m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1, and err out 1 (sticky write error).

Function
REQ-011 SHALL implement states IDLE, AW, W, B, DONE.
REQ-012 In IDLE, ap_idle=1; on ap_start it SHALL assert ap_ready for exactly 1 cycle and latch base_addr and size. With size!=0 it SHALL go to AW; with size==0 it SHALL go to DONE.
REQ-013 In AW it SHALL assert awvalid with awlen=min(remaining,MAX_BURST)-1, awsize=log2(WIDTH/8) and awburst=INCR. All AW fields SHALL stay stable until awready; it SHALL go to W on awvalid&&awready.
REQ-014 The FIFO read SHALL have 1-cycle latency: fifo_rd_data is valid the cycle after fifo_rd_en=1.
REQ-015 fifo_rd_en SHALL only be asserted when !fifo_empty, in state W, while the beats-requested count for the burst is below the burst length, and when the 2-entry holding buffer will have room.
REQ-016 wvalid SHALL be asserted whenever the holding buffer is non-empty, with wdata taken from the buffer head and wstrb all ones.
REQ-017 A beat SHALL be consumed on wvalid&&wready, and wlast SHALL be 1 on the final beat of the burst.
REQ-018 fifo_empty during a burst SHALL stall wvalid and SHALL NOT drop or duplicate data. Simultaneous buffer push and pop SHALL keep the occupancy unchanged.
REQ-019 After the last beat is accepted it SHALL go to B. It SHALL assert bready and wait for bvalid.
REQ-020 On bvalid&&bready it SHALL decrement remaining and advance the address by (awlen+1)*WIDTH/8. It SHALL go to AW if remaining>0, else to DONE.
REQ-021 In DONE it SHALL assert ap_done for 1 cycle and go to IDLE.
REQ-022 The AW, W and B phases of successive bursts SHALL NOT overlap: one outstanding transaction only.
REQ-023 remaining and the address SHALL be 32-bit; address wrap past 2^32 is unsupported and not checked.
REQ-024 ap_start while not in IDLE SHALL be ignored.

Reset
REQ-025 On ap_rst_n low, all outputs SHALL be 0 except ap_idle=1, the state SHALL be IDLE, the holding buffer SHALL be empty and err SHALL be cleared.
REQ-026 Reset mid-burst SHALL abandon the transaction immediately; there is no completion of a partial AXI burst.

Configuration
REQ-027 With FIFO_AXI_WRITER_BRESP_CHECK_EN defined, err SHALL go to 1 on any bvalid&&bready with bresp!=0, hold until reset or the next accepted ap_start, and leave the transfer flow unchanged.
REQ-028 Without FIFO_AXI_WRITER_BRESP_CHECK_EN, err SHALL be tied to 0 and bresp SHALL be ignored.

Verification
REQ-029 base 0x1000, size 16, MAX_BURST 16, slave always ready, FIFO holds 0..15 -> one AW (awaddr 0x1000, awlen 15), wdata 0..15, wlast on the 16th beat, ap_done 1 cycle after the B handshake.
REQ-030 size 40, WIDTH 32 -> AW bursts at 0x1000/len15, 0x1040/len15 and 0x1080/len7; 40 beats in order; a single ap_done.
REQ-031 size 0 -> ap_ready, then ap_done on the next cycle, with no AXI or FIFO activity.
REQ-032 FIFO empty for 5 cycles mid-burst and wready toggling randomly -> wdata sequence gapless and correct, and fifo_rd_en never asserted while fifo_empty=1.
REQ-033 With BRESP_CHECK_EN, bresp=SLVERR on burst 2 of 3 -> err=1 from then on, all 3 bursts complete, ap_done asserted; err cleared by the next ap_start.
REQ-034 ap_rst_n low during the 3rd W beat -> all outputs at reset values asynchronously, ap_idle=1; a new ap_start then runs normally.
